dmem_bus_arbiter: RTL

Shares the processor's data-memory/I/O bus between two requesters: M0 = CPU data port, M1 = program loader / debug port.
- Decodes each accepted access to DMEM, the memory-mapped I/O block (KEY/SW/HEX/LEDR/LEDG) or unmapped space.
- Issues it to the one target and returns read data one cycle later, tagged to the owner.
- Sits between the Project2 core pipeline, the DMEM instance and the I/O register block.

---
 rtl/dmem_bus_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 81 ++++++++
 rtl/dmem_bus_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dmem_bus_pkg.sv
// Shared constants and types for the data-memory / I/O bus arbiter.
// Used by dmem_bus_arbiter and rr_arbiter2.
package dmem_bus_pkg;

    localparam logic [7:0]  ADDR_HEX  = 8'h00;
    localparam logic [7:0]  ADDR_LEDR = 8'h04;
    localparam logic [7:0]  ADDR_LEDG = 8'h08;
    localparam logic [7:0]  ADDR_KEY  = 8'h10;
    localparam logic [7:0]  ADDR_SW   = 8'h14;

    localparam logic [3:0]  IO_BASE_NIBBLE = 4'hF;
    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEADBEEF;

    localparam int unsigned M_CPU = 0;
    localparam int unsigned M_LDR = 1;

    typedef enum logic [1:0] {
        TGT_DMEM  = 2'd0,
        TGT_IO    = 2'd1,
        TGT_UNMAP = 2'd2
    } tgt_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a 1-bit priority pointer.
// Optional bus locking is compiled in with ARB_LOCK_EN.
module rr_arbiter2
    import dmem_bus_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic [1:0] gnt_o
);

    logic       prio_q, prio_d;
    logic [1:0] elig;

`ifdef ARB_LOCK_EN
    logic lock_act_q, lock_act_d;
    logic lock_own_q, lock_own_d;
`else
    logic [1:0] unused_lock;
    assign unused_lock = lock_i;
`endif

    always_comb begin
        elig = req_i;
`ifdef ARB_LOCK_EN
        if (lock_act_q) begin
            elig = req_i & (lock_own_q ? 2'b10 : 2'b01);
        end
`endif
        gnt_o = elig;
        if (elig == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end
    end

    // The loser of this grant becomes the favoured master.
    always_comb begin
        prio_d = prio_q;
        if (|gnt_o) begin
            prio_d = ~gnt_o[M_LDR];
        end
    end

`ifdef ARB_LOCK_EN
    // While locked only the owner can be granted, so any grant seen here
    // with the lock active belongs to the owner.
    always_comb begin
        lock_act_d = lock_act_q;
        lock_own_d = lock_own_q;
        if (lock_act_q && !req_i[lock_own_q]) begin
            lock_act_d = 1'b0;
        end
        if (|gnt_o) begin
            if (lock_i[gnt_o[M_LDR]]) begin
                lock_act_d = 1'b1;
                lock_own_d = gnt_o[M_LDR];
            end else if (lock_act_q) begin
                lock_act_d = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_act_q <= 1'b0;
            lock_own_q <= 1'b0;
`endif
        end else begin
            prio_q <= prio_d;
`ifdef ARB_LOCK_EN
            lock_act_q <= lock_act_d;
            lock_own_q <= lock_own_d;
`endif
        end
    end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Shares the data bus between the CPU (M0) and the loader/debug port (M1),
// decoding each grant to DMEM, I/O or unmapped space. Locking: ARB_LOCK_EN.
module dmem_bus_arbiter
    import dmem_bus_pkg::*;
#(
    parameter int DBITS        = 32,
    parameter int DMEMADDRBITS = 13,
    parameter int DMEMWORDBITS = 2,
    parameter int DMEMWORDS    = 2048
) (
    input  logic                                 CLOCK_50,
    input  logic                                 RESET,
    input  logic [1:0]                           m_req,
    input  logic [1:0]                           m_we,
    input  logic [1:0]                           m_lock,
    input  logic [DBITS-1:0]                     m0_addr,
    input  logic [DBITS-1:0]                     m1_addr,
    input  logic [DBITS-1:0]                     m0_wdata,
    input  logic [DBITS-1:0]                     m1_wdata,
    output logic [1:0]                           m_gnt,
    output logic [1:0]                           m_rvalid,
    output logic [DBITS-1:0]                     m_rdata,
    output logic                                 mem_we,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
    output logic [DBITS-1:0]                     mem_wdata,
    input  logic [DBITS-1:0]                     mem_rdata,
    output logic                                 io_we,
    output logic                                 io_re,
    output logic [7:0]                           io_addr,
    output logic [DBITS-1:0]                     io_wdata,
    input  logic [DBITS-1:0]                     io_rdata
);

    localparam logic [DBITS-1:0] DMEM_LIMIT = DBITS'(DMEMWORDS * 4);

    logic [1:0]       gnt;
    logic             gnt_any;
    logic             sel_m;
    logic [DBITS-1:0] sel_addr;
    logic [DBITS-1:0] sel_wdata;
    logic             sel_we;
    tgt_e             tgt;

    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;
    tgt_e             rd_src_q, rd_src_d;
    logic [DBITS-1:0] io_rd_q, io_rd_d;

    logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr_q;
    logic [7:0]                           io_addr_q;
    logic [DBITS-1:0]                     wdata_q;

    // Nothing is accepted while reset is held.
    rr_arbiter2 u_arb (
        .clk_i  (CLOCK_50),
        .rst_i  (RESET),
        .req_i  (m_req & {2{~RESET}}),
        .lock_i (m_lock),
        .gnt_o  (gnt)
    );

    assign m_gnt   = gnt;
    assign gnt_any = |gnt;
    assign sel_m   = gnt[M_LDR];

    always_comb begin
        sel_addr  = sel_m ? m1_addr  : m0_addr;
        sel_wdata = sel_m ? m1_wdata : m0_wdata;
        sel_we    = m_we[sel_m];
    end

    always_comb begin
        tgt = TGT_UNMAP;
        if (sel_addr[DBITS-1 -: 4] == IO_BASE_NIBBLE) begin
            tgt = TGT_IO;
        end else if (sel_addr < DMEM_LIMIT) begin
            tgt = TGT_DMEM;
        end
    end

    // Unmapped writes fall through with no strobe.
    always_comb begin
        mem_we = gnt_any && sel_we && (tgt == TGT_DMEM);
        io_we  = gnt_any && sel_we && (tgt == TGT_IO);
        io_re  = gnt_any && !sel_we && (tgt == TGT_IO);
    end

    always_comb begin
        mem_addr  = mem_addr_q;
        io_addr   = io_addr_q;
        mem_wdata = wdata_q;
        io_wdata  = wdata_q;
        if (gnt_any) begin
            mem_addr  = sel_addr[DMEMADDRBITS-1:DMEMWORDBITS];
            io_addr   = sel_addr[7:0];
            mem_wdata = sel_wdata;
            io_wdata  = sel_wdata;
        end
    end

    always_comb begin
        rd_pend_d  = gnt_any && !sel_we;
        rd_owner_d = rd_owner_q;
        rd_src_d   = rd_src_q;
        io_rd_d    = io_rd_q;
        if (gnt_any && !sel_we) begin
            rd_owner_d = sel_m;
            rd_src_d   = tgt;
        end
        if (io_re) begin
            io_rd_d = io_rdata;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            rd_src_q   <= TGT_DMEM;
            io_rd_q    <= '0;
            mem_addr_q <= '0;
            io_addr_q  <= '0;
            wdata_q    <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            rd_src_q   <= rd_src_d;
            io_rd_q    <= io_rd_d;
            if (gnt_any) begin
                mem_addr_q <= sel_addr[DMEMADDRBITS-1:DMEMWORDBITS];
                io_addr_q  <= sel_addr[7:0];
                wdata_q    <= sel_wdata;
            end
        end
    end

    // A read still pending when reset arrives must never be reported.
    always_comb begin
        m_rvalid = 2'b00;
        m_rdata  = '0;
        if (rd_pend_q && !RESET) begin
            m_rvalid = rd_owner_q ? 2'b10 : 2'b01;
            case (rd_src_q)
                TGT_DMEM: m_rdata = mem_rdata;
                TGT_IO:   m_rdata = io_rd_q;
                default:  m_rdata = DBITS'(UNMAPPED_RDATA);
            endcase
        end
    end

endmodule
